// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared definitions for the HI/LO multiply/divide unit:
//   - op_e      : operation encodings presented on i_op
//   - state_e   : sequencer states of the unit
//   - DIV_ZERO_FILL : fill bit for the default LO value on divide-by-zero
//   - is_signed_op  : true for the two's-complement variants (MULT, DIV)
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    // Default LO on divide-by-zero is all ones at whatever width is chosen.
    localparam logic DIV_ZERO_FILL = 1'b1;

    function automatic logic is_signed_op(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// -----------------------------------------------------------------------------
// muldiv_div_core
// Iterative restoring divider working on operand magnitudes, one quotient bit
// per i_step cycle. Sign correction of the results is combinational on the
// final registers so it is ready in the sequencer's FIX cycle.
// Ports:
//   i_clock, i_reset : clock and synchronous active-high reset
//   i_load           : latch operands and clear the iteration counter
//   i_op             : operation (selects signed/unsigned handling)
//   i_a, i_b         : dividend, divisor (sampled on i_load)
//   i_step           : perform one iteration this cycle
//   o_last           : current step is the final (WIDTH-th) iteration
//   o_quo, o_rem     : sign-corrected quotient and remainder
// -----------------------------------------------------------------------------
module muldiv_div_core
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_step,
    output logic             o_last,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;     // partial remainder
    logic [WIDTH-1:0] r_quo;     // dividend bits shift out the top, quotient bits in
    logic [WIDTH-1:0] r_div;     // divisor magnitude
    logic             r_q_neg;
    logic             r_r_neg;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    assign w_signed = is_signed_op(op_e'(i_op));
    assign w_a_neg  = w_signed & i_a[WIDTH-1];
    assign w_b_neg  = w_signed & i_b[WIDTH-1];

    // Trial subtraction: the top bit of w_diff is the borrow, so a clear top
    // bit means the shifted remainder is at least the divisor.
    assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_div};
    assign w_fits      = ~w_diff[WIDTH];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_step) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_load) begin
            r_rem   <= '0;
            r_quo   <= w_a_neg ? -i_a : i_a;
            r_div   <= w_b_neg ? -i_b : i_b;
            r_q_neg <= w_a_neg ^ w_b_neg;
            r_r_neg <= w_a_neg;
        end else if (i_step) begin
            r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_fits};
        end
    end

    assign o_last = (r_cnt == LAST_ITER);
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    // Most-negative / -1 yields magnitude 2^(WIDTH-1) with no negation, which
    // is the most-negative value again.
    assign o_quo  = r_q_neg ? -r_quo : r_quo;
    assign o_rem  = r_r_neg ? -r_rem : r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// HI/LO multiply/divide unit for the EX stage. Owns the HI/LO registers,
// performs MULT/MULTU (single-cycle or shift-add), DIV/DIVU (iterative),
// MTHI/MTLO, and requests a stall while an operation is in flight.
// Ports:
//   i_clock, i_reset : clock and synchronous active-high reset
//   i_start, i_op    : operation request, accepted only when not busy
//   i_a, i_b         : rs/dividend/MT source, rt/divisor
//   i_flush          : squash the in-flight or just-requested operation
//   i_read_hilo      : EX holds MFHI/MFLO
//   o_hi, o_lo       : HI/LO registers
//   o_busy           : iterative operation in progress
//   o_done           : one-cycle pulse after HI/LO were written
//   o_stall          : busy and (MFHI/MFLO or new start) in EX
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int               WIDTH         = 32,
    parameter bit               MUL_ITERATIVE = 1'b0,
    parameter logic [WIDTH-1:0] DIV_ZERO_LO   = {WIDTH{DIV_ZERO_FILL}}
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    input  logic             i_read_hilo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_stall
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);

    state_e             r_state;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic [WIDTH-1:0]   r_op_a;
    logic               r_div_zero;
    logic [2*WIDTH-1:0] r_mul_p;      // {accumulator, remaining multiplier bits}
    logic [WIDTH-1:0]   r_mul_mcand;
    logic               r_mul_neg;
    logic [CW-1:0]      r_mul_cnt;

    op_e                w_op;
    logic               w_busy;
    logic               w_accept;
    logic               w_is_div;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_mul_res;
    logic               w_div_last;
    logic [WIDTH-1:0]   w_div_quo;
    logic [WIDTH-1:0]   w_div_rem;

    assign w_op     = op_e'(i_op);
    assign w_busy   = (r_state != S_IDLE);
    assign w_accept = i_start & ~w_busy & ~i_flush;
    assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
    assign w_signed = is_signed_op(w_op);
    assign w_a_neg  = w_signed & i_a[WIDTH-1];
    assign w_b_neg  = w_signed & i_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;

    // Single-cycle product: extending both operands to 2*WIDTH and keeping the
    // low 2*WIDTH bits gives the exact signed or unsigned product.
    assign w_a_ext = {{WIDTH{w_a_neg}}, i_a};
    assign w_b_ext = {{WIDTH{w_b_neg}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Shift-add step on magnitudes; the carry out of the add re-enters as the
    // top bit after the right shift, so no extra register bit is needed.
    assign w_mul_sum  = {1'b0, r_mul_p[2*WIDTH-1:WIDTH]}
                      + (r_mul_p[0] ? {1'b0, r_mul_mcand} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_mul_p[WIDTH-1:1]};
    assign w_mul_res  = r_mul_neg ? -w_mul_next : w_mul_next;

    muldiv_div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (w_accept & w_is_div),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_step  ((r_state == S_DIV) & ~i_flush),
        .o_last  (w_div_last),
        .o_quo   (w_div_quo),
        .o_rem   (w_div_rem)
    );

    // NOTE: operand/datapath registers carry no reset; they are always loaded
    // on accept before the sequencer reads them, so reset only the control.
    always_ff @(posedge i_clock) begin
        if (w_accept) begin
            r_op_a      <= i_a;
            r_div_zero  <= (i_b == '0);
            r_mul_p     <= {{WIDTH{1'b0}}, w_b_mag};
            r_mul_mcand <= w_a_mag;
            r_mul_neg   <= w_a_neg ^ w_b_neg;
            r_mul_cnt   <= '0;
        end else if (r_state == S_MUL) begin
            r_mul_p   <= w_mul_next;
            r_mul_cnt <= r_mul_cnt + CW'(1);
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_MULT, OP_MULTU: begin
                                if (MUL_ITERATIVE) begin
                                    r_state <= S_MUL;
                                end else begin
                                    {r_hi, r_lo} <= w_prod;
                                    r_done       <= 1'b1;
                                end
                            end
                            // A zero divisor skips iteration and goes straight to FIX.
                            OP_DIV, OP_DIVU: r_state <= (i_b == '0) ? S_FIX : S_DIV;
                            OP_MTHI: begin
                                r_hi   <= i_a;
                                r_done <= 1'b1;
                            end
                            OP_MTLO: begin
                                r_lo   <= i_a;
                                r_done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                    end else if (r_mul_cnt == MUL_LAST) begin
                        {r_hi, r_lo} <= w_mul_res;
                        r_done       <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                S_DIV: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                    end else if (w_div_last) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (r_div_zero) begin
                            r_hi <= r_op_a;
                            r_lo <= DIV_ZERO_LO;
                        end else begin
                            r_hi <= w_div_rem;
                            r_lo <= w_div_quo;
                        end
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_busy  = w_busy;
    assign o_done  = r_done;
    assign o_stall = w_busy & (i_read_hilo | i_start);

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Drives one stimulus stream into two instances (single-cycle and shift-add
// multiply) and compares both every cycle against a transaction-level model:
// each accepted op is evaluated with plain arithmetic and committed after its
// architectural latency unless flushed or reset first.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic         rd = 1'b0;
    logic [2:0]   op = 3'd7;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic [W-1:0] hi [2];
    logic [W-1:0] lo [2];
    logic         busy [2];
    logic         done [2];
    logic         stall [2];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .MUL_ITERATIVE(1'b0)) dut0 (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
        .i_flush(flush), .i_read_hilo(rd), .o_hi(hi[0]), .o_lo(lo[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_stall(stall[0])
    );

    muldiv_unit #(.WIDTH(W), .MUL_ITERATIVE(1'b1)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
        .i_flush(flush), .i_read_hilo(rd), .o_hi(hi[1]), .o_lo(lo[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_stall(stall[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result and latency (cycles of Busy) of one accepted op.
    function automatic void model_op(input logic [2:0] o, input logic [W-1:0] x, y,
                                     input bit iter, input logic [W-1:0] oh, ol,
                                     output logic [W-1:0] nh, nl,
                                     output int lat, output bit ok);
        longint       sx, sy, sq, sr;
        logic [63:0]  p;
        nh = oh; nl = ol; lat = 0; ok = 1'b1;
        case (o)
            3'd0: begin
                sx = longint'($signed(x)); sy = longint'($signed(y));
                p = sx * sy; nh = p[63:32]; nl = p[31:0]; lat = iter ? W : 0;
            end
            3'd1: begin
                p = {32'd0, x} * {32'd0, y}; nh = p[63:32]; nl = p[31:0]; lat = iter ? W : 0;
            end
            3'd2, 3'd3: begin
                if (y == '0) begin
                    nh = x; nl = '1; lat = 1;
                end else begin
                    if (o == 3'd2) begin
                        sx = longint'($signed(x)); sy = longint'($signed(y));
                    end else begin
                        sx = longint'({32'd0, x}); sy = longint'({32'd0, y});
                    end
                    sq = sx / sy; sr = sx % sy;
                    p = sq; nl = p[31:0];
                    p = sr; nh = p[31:0];
                    lat = W + 1;
                end
            end
            3'd4: nh = x;
            3'd5: nl = x;
            default: ok = 1'b0;
        endcase
    endfunction

    // Reference state per instance
    logic [W-1:0] m_hi [2];
    logic [W-1:0] m_lo [2];
    logic [W-1:0] p_hi [2];
    logic [W-1:0] p_lo [2];
    bit           m_pend [2] = '{1'b0, 1'b0};
    bit           m_done [2] = '{1'b0, 1'b0};
    int           m_rem  [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [W-1:0] nh, nl;
            int           lat;
            bit           ok;
            m_done[k] = 1'b0;
            if (rst) begin
                m_hi[k] = '0; m_lo[k] = '0; m_pend[k] = 1'b0;
            end else if (m_pend[k]) begin
                if (flush) begin
                    m_pend[k] = 1'b0;
                end else begin
                    m_rem[k]--;
                    if (m_rem[k] == 0) begin
                        m_hi[k] = p_hi[k]; m_lo[k] = p_lo[k];
                        m_done[k] = 1'b1; m_pend[k] = 1'b0;
                    end
                end
            end else if (start && !flush) begin
                model_op(op, a, b, k == 1, m_hi[k], m_lo[k], nh, nl, lat, ok);
                if (ok) begin
                    if (lat == 0) begin
                        m_hi[k] = nh; m_lo[k] = nl; m_done[k] = 1'b1;
                    end else begin
                        p_hi[k] = nh; p_lo[k] = nl; m_pend[k] = 1'b1; m_rem[k] = lat;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("busy%0d", k), busy[k], m_pend[k]);
                check($sformatf("done%0d", k), done[k], m_done[k]);
                check($sformatf("stall%0d", k), stall[k], m_pend[k] & (rd | start));
                check($sformatf("hi%0d", k), hi[k], m_hi[k]);
                check($sformatf("lo%0d", k), lo[k], m_lo[k]);
            end
        end
    end

    // Present an op for exactly one cycle; afterwards A/B are scrambled.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, y);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd7; a = $urandom; b = $urandom;
    endtask

    // Wait (bounded) for Done of instance k; counts Busy cycles seen before it.
    task automatic wait_done(input int k, input int max, output int bc);
        bit seen = 1'b0;
        bc = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done[k]) begin
                seen = 1'b1;
                break;
            end
            if (busy[k]) bc++;
        end
        check($sformatf("done_seen%0d", k), seen, 1'b1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 8)
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'h7fff_ffff;
            5: return W'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] nh, nl;
        int           lat, bc;
        bit           ok;

        // Pin the model with hand-computed values
        model_op(3'd2, 32'hffff_fff9, 32'd2, 1'b0, '0, '0, nh, nl, lat, ok);
        check("pin_div_lo", nl, 32'hffff_fffd);
        check("pin_div_hi", nh, 32'hffff_ffff);
        check("pin_div_lat", lat, 33);
        model_op(3'd0, 32'hffff_ffff, 32'd1, 1'b1, '0, '0, nh, nl, lat, ok);
        check("pin_mult", {nh, nl}, 64'hffff_ffff_ffff_ffff);
        check("pin_mult_lat", lat, 32);
        model_op(3'd1, 32'hffff_ffff, 32'd1, 1'b0, '0, '0, nh, nl, lat, ok);
        check("pin_multu", {nh, nl}, 64'h0000_0000_ffff_ffff);
        model_op(3'd3, 32'd5, 32'd0, 1'b0, '0, '0, nh, nl, lat, ok);
        check("pin_div0", {nh, nl}, 64'h0000_0005_ffff_ffff);
        check("pin_div0_lat", lat, 1);
        model_op(3'd2, 32'h8000_0000, 32'hffff_ffff, 1'b0, '0, '0, nh, nl, lat, ok);
        check("pin_ovf", {nh, nl}, 64'h0000_0000_8000_0000);

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; chk_en = 1'b1; rst = 1'b0;
        @(negedge clk);
        check("rst_hi", hi[0], 32'd0);
        check("rst_lo", lo[0], 32'd0);
        check("rst_busy", busy[0], 1'b0);
        check("rst_done", done[0], 1'b0);

        // 1: DIVU timing and values
        issue(3'd3, 32'd6, 32'd3);
        wait_done(0, 60, bc);
        check("divu_busy_cycles", bc, 33);
        check("divu6_3", {hi[0], lo[0]}, 64'h0000_0000_0000_0002);
        @(negedge clk);
        check("divu_done_pulse", done[0], 1'b0);
        issue(3'd3, 32'd1, 32'd3);
        wait_done(0, 60, bc);
        check("divu1_3", {hi[0], lo[0]}, 64'h0000_0001_0000_0000);
        issue(3'd3, 32'd11, 32'd3);
        wait_done(0, 60, bc);
        check("divu11_3", {hi[0], lo[0]}, 64'h0000_0002_0000_0003);

        // 2: multiplies, shift-add instance gives the Busy count
        issue(3'd0, 32'hffff_ffff, 32'd1);
        wait_done(1, 60, bc);
        check("mult_iter_busy", bc, 32);
        check("mult0", {hi[0], lo[0]}, 64'hffff_ffff_ffff_ffff);
        check("mult1", {hi[1], lo[1]}, 64'hffff_ffff_ffff_ffff);
        issue(3'd1, 32'hffff_ffff, 32'd1);
        wait_done(1, 60, bc);
        check("multu0", {hi[0], lo[0]}, 64'h0000_0000_ffff_ffff);
        check("multu1", {hi[1], lo[1]}, 64'h0000_0000_ffff_ffff);
        issue(3'd0, 32'hffff_ffff, 32'd0);
        wait_done(1, 60, bc);
        check("mult_zero", {hi[1], lo[1]}, 64'd0);

        // 3: signed divide and divide-by-zero
        issue(3'd2, 32'hffff_fff9, 32'd2);
        wait_done(0, 60, bc);
        check("div_m7_2", {hi[0], lo[0]}, 64'hffff_ffff_ffff_fffd);
        issue(3'd2, 32'h8000_0000, 32'hffff_ffff);
        wait_done(0, 60, bc);
        check("div_ovf", {hi[0], lo[0]}, 64'h0000_0000_8000_0000);
        issue(3'd3, 32'd5, 32'd0);
        wait_done(0, 10, bc);
        check("div0_busy", bc, 1);
        check("div0_val", {hi[0], lo[0]}, 64'h0000_0005_ffff_ffff);

        // 4: reset mid-divide
        issue(3'd4, 32'd0, 32'd0);
        issue(3'd5, 32'd0, 32'd0);
        issue(3'd3, 32'd10, 32'd3);
        repeat (9) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", busy[0], 1'b0);
        check("rst_mid_hilo", {hi[0], lo[0]}, 64'd0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("rst_mid_nodone", done[0], 1'b0);
        end
        issue(3'd3, 32'd11, 32'd3);
        wait_done(0, 60, bc);
        check("after_rst_div", {hi[0], lo[0]}, 64'h0000_0002_0000_0003);

        // 5: flush mid-divide
        issue(3'd4, 32'd1234, 32'd0);
        issue(3'd5, 32'd5678, 32'd0);
        issue(3'd2, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        check("flush_busy", busy[0], 1'b0);
        check("flush_hilo", {hi[0], lo[0]}, {32'd1234, 32'd5678});
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("flush_nodone", done[0], 1'b0);
        end

        // 6: stall hold, ignored mid-op start, start in Done cycle
        rd = 1'b1;
        issue(3'd3, 32'd100, 32'd9);
        repeat (5) @(posedge clk);
        #1; start = 1'b1; op = 3'd4; a = 32'hffff;
        @(negedge clk);
        check("stall_midstart", stall[0], 1'b1);
        @(posedge clk); #1; start = 1'b0; op = 3'd7;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (done[0]) begin
                    seen = 1'b1;
                    break;
                end
                check("stall_hold", stall[0], 1'b1);
            end
            check("stall_done_seen", seen, 1'b1);
        end
        check("stall_done_cycle", stall[0], 1'b0);
        check("divu100_9", {hi[0], lo[0]}, 64'h0000_0001_0000_000b);
        #1; start = 1'b1; op = 3'd5; a = 32'd77;
        @(posedge clk); #1; start = 1'b0; op = 3'd7; rd = 1'b0;
        @(negedge clk);
        check("start_in_done", {hi[0], lo[0]}, {32'd1, 32'd77});

        // 7: random regression
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            start = ($urandom % 2) == 0;
            op    = 3'($urandom % 8);
            a     = pick();
            b     = pick();
            flush = ($urandom % 64) == 0;
            rd    = ($urandom % 2) == 0;
            rst   = ($urandom % 1024) == 0;
        end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; rd = 1'b0; rst = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
